// File: rtl/multiplier_pipe_pkg.sv
// Shared types and sizing helpers for the parametrised execute-stage multiplier.
package multiplier_pipe_pkg;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic half;
  } mul_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam int MUL_LAT_MAX = 3;
  localparam int MUL_CNT_W   = $clog2(MUL_LAT_MAX);

  function automatic int mul_pp_w(int width, int chunk);
    return (width / chunk) * (width / chunk) * 2 * chunk;
  endfunction

  // Column sums need headroom for up to N partial products landing in one column.
  function automatic int mul_sum_w(int width, int chunk);
    return 2 * chunk + $clog2(width / chunk) + 1;
  endfunction

  function automatic int mul_col_w(int width, int chunk);
    return (2 * (width / chunk) - 1) * mul_sum_w(width, chunk);
  endfunction

endpackage

// File: rtl/multiplier_pipe_array.sv
// Combinational chunked multiplier core: partial products, column sums and the
// final shifted accumulation, each exposed so the caller can register between them.
module mul_partial_array
  import multiplier_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic [WIDTH-1:0]                    i_a,
  input  logic [WIDTH-1:0]                    i_b,
  output logic [mul_pp_w(WIDTH, CHUNK)-1:0]   o_pp,
  input  logic [mul_pp_w(WIDTH, CHUNK)-1:0]   i_pp,
  output logic [mul_col_w(WIDTH, CHUNK)-1:0]  o_col,
  input  logic [mul_col_w(WIDTH, CHUNK)-1:0]  i_col,
  output logic [2*WIDTH-1:0]                  o_prod
);

  localparam int N    = WIDTH / CHUNK;
  localparam int PPE  = 2 * CHUNK;
  localparam int SW   = mul_sum_w(WIDTH, CHUNK);
  localparam int NCOL = 2 * N - 1;
  localparam int PW   = 2 * WIDTH;

  logic [SW-1:0] w_sum [NCOL];

  always_comb begin
    o_pp = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        o_pp[(i*N+j)*PPE +: PPE] = PPE'(i_a[i*CHUNK +: CHUNK]) * PPE'(i_b[j*CHUNK +: CHUNK]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCOL; k++) begin
      w_sum[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_sum[i+j] = w_sum[i+j] + SW'(i_pp[(i*N+j)*PPE +: PPE]);
      end
    end
  end

  always_comb begin
    o_col = '0;
    for (int k = 0; k < NCOL; k++) begin
      o_col[k*SW +: SW] = w_sum[k];
    end
  end

  always_comb begin
    o_prod = '0;
    for (int k = 0; k < NCOL; k++) begin
      o_prod = o_prod + (PW'(i_col[k*SW +: SW]) << (k * CHUNK));
    end
  end

endmodule

// File: rtl/multiplier_pipe.sv
// Multi-cycle signed/unsigned integer multiplier with half-width mode, a
// configurable 1..3 stage latency and a synchronous pipeline-kill flush.
module multiplier_pipe
  import multiplier_pipe_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int CHUNK   = 16,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               half,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int HW   = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;
  localparam int PPW  = mul_pp_w(WIDTH, CHUNK);
  localparam int COLW = mul_col_w(WIDTH, CHUNK);
  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(LATENCY - 1);
  localparam logic [MUL_CNT_W-1:0] CNT_PRE  = MUL_CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  function automatic logic [WIDTH-1:0] op_extend(logic [WIDTH-1:0] x, logic sgn, logic hm);
    if (hm) return {{HW{sgn & x[HW-1]}}, x[HW-1:0]};
    else    return x;
  endfunction

  function automatic logic [WIDTH-1:0] op_magnitude(logic [WIDTH-1:0] x, logic neg);
    return neg ? -x : x;
  endfunction

  // Negation of zero stays zero, so no negative-zero or carry-out can appear.
  function automatic logic [PW-1:0] sign_fix(logic [PW-1:0] p, logic neg, logic hm);
    logic [PW-1:0] r;
    r = neg ? -p : p;
    if (hm) r = {{(PW-HW){r[HW-1]}}, r[HW-1:0]};
    return r;
  endfunction

  mul_state_t           r_state, w_state_nxt;
  logic [MUL_CNT_W-1:0] r_cnt, w_cnt_nxt;
  mul_mode_t            w_mode_p0;
  logic [WIDTH-1:0]     w_a_p0, w_b_p0, w_ma_p0, w_mb_p0;
  logic                 w_neg_p0, w_vld_p0, w_load_c;
  logic [PPW-1:0]       w_pp_p0, w_pp_s1;
  logic                 w_neg_s1, w_half_s1;
  logic [COLW-1:0]      w_col_p1, w_col_s2;
  logic                 w_neg_s2, w_half_s2;
  logic [PW-1:0]        w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    done        = 1'b1;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == IDLE) begin
      if (valid) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = '0;
        done        = 1'b0;
      end
    end else if (r_cnt == CNT_LAST) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt + MUL_CNT_W'(1);
      done      = 1'b0;
    end
    if (reset) done = !valid;
  end

  assign w_vld_p0 = (r_state == IDLE) && valid && !flush;
  assign w_load_c = (LATENCY == 1) ? w_vld_p0
                                   : ((r_state == BUSY) && (r_cnt == CNT_PRE) && !flush);

  // p0: operand extension, magnitude conversion and result sign
  always_comb begin
    w_mode_p0 = {a_signed, b_signed, half};
    w_a_p0    = op_extend(a, w_mode_p0.a_signed, w_mode_p0.half);
    w_b_p0    = op_extend(b, w_mode_p0.b_signed, w_mode_p0.half);
    w_ma_p0   = op_magnitude(w_a_p0, w_mode_p0.a_signed & w_a_p0[WIDTH-1]);
    w_mb_p0   = op_magnitude(w_b_p0, w_mode_p0.b_signed & w_b_p0[WIDTH-1]);
    w_neg_p0  = (w_mode_p0.a_signed & w_a_p0[WIDTH-1]) ^ (w_mode_p0.b_signed & w_b_p0[WIDTH-1]);
  end

  mul_partial_array #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_array (
    .i_a    (w_ma_p0),
    .i_b    (w_mb_p0),
    .o_pp   (w_pp_p0),
    .i_pp   (w_pp_s1),
    .o_col  (w_col_p1),
    .i_col  (w_col_s2),
    .o_prod (w_prod)
  );

  // p1: registered partial products
  if (LATENCY >= 2) begin : g_stage1
    logic [PPW-1:0] r_pp_p1;
    logic           r_neg_p1, r_half_p1;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_pp_p1   <= '0;
        r_neg_p1  <= 1'b0;
        r_half_p1 <= 1'b0;
      end else if (w_vld_p0) begin
        r_pp_p1   <= w_pp_p0;
        r_neg_p1  <= w_neg_p0;
        r_half_p1 <= w_mode_p0.half;
      end
    end
    assign w_pp_s1   = r_pp_p1;
    assign w_neg_s1  = r_neg_p1;
    assign w_half_s1 = r_half_p1;
  end else begin : g_stage1_bypass
    assign w_pp_s1   = w_pp_p0;
    assign w_neg_s1  = w_neg_p0;
    assign w_half_s1 = w_mode_p0.half;
  end

  // p2: registered column sums
  if (LATENCY >= 3) begin : g_stage2
    logic            w_vld_p1;
    logic [COLW-1:0] r_col_p2;
    logic            r_neg_p2, r_half_p2;
    assign w_vld_p1 = (r_state == BUSY) && (r_cnt == '0) && !flush;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_col_p2  <= '0;
        r_neg_p2  <= 1'b0;
        r_half_p2 <= 1'b0;
      end else if (w_vld_p1) begin
        r_col_p2  <= w_col_p1;
        r_neg_p2  <= w_neg_s1;
        r_half_p2 <= w_half_s1;
      end
    end
    assign w_col_s2  = r_col_p2;
    assign w_neg_s2  = r_neg_p2;
    assign w_half_s2 = r_half_p2;
  end else begin : g_stage2_bypass
    assign w_col_s2  = w_col_p1;
    assign w_neg_s2  = w_neg_s1;
    assign w_half_s2 = w_half_s1;
  end

  // final stage: sign-corrected result, held until the next completion
  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
    end else if (w_load_c) begin
      c <= sign_fix(w_prod, w_neg_s2, w_half_s2);
    end
  end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed and golden-model bench for multiplier_pipe across latencies 1..3
// and a 32-bit / 8-bit-chunk variant.
module tb_multiplier_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid [4];
  logic        in_flush [4];
  logic        in_as    [4];
  logic        in_bs    [4];
  logic        in_h     [4];
  logic [63:0] in_a     [4];
  logic [63:0] in_b     [4];

  logic         done0, done1, done2, done3;
  logic [127:0] c0, c1, c2;
  logic [63:0]  c3;

  int checks = 0;
  int errors = 0;
  int lat_of [4] = '{1, 2, 3, 2};

  multiplier_pipe #(.WIDTH(64), .CHUNK(16), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(rst), .valid(in_valid[0]), .flush(in_flush[0]),
    .a(in_a[0]), .b(in_b[0]), .a_signed(in_as[0]), .b_signed(in_bs[0]),
    .half(in_h[0]), .done(done0), .c(c0));

  multiplier_pipe #(.WIDTH(64), .CHUNK(16), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(rst), .valid(in_valid[1]), .flush(in_flush[1]),
    .a(in_a[1]), .b(in_b[1]), .a_signed(in_as[1]), .b_signed(in_bs[1]),
    .half(in_h[1]), .done(done1), .c(c1));

  multiplier_pipe #(.WIDTH(64), .CHUNK(16), .LATENCY(3)) dut_l3 (
    .clk(clk), .reset(rst), .valid(in_valid[2]), .flush(in_flush[2]),
    .a(in_a[2]), .b(in_b[2]), .a_signed(in_as[2]), .b_signed(in_bs[2]),
    .half(in_h[2]), .done(done2), .c(c2));

  multiplier_pipe #(.WIDTH(32), .CHUNK(8), .LATENCY(2)) dut_w32 (
    .clk(clk), .reset(rst), .valid(in_valid[3]), .flush(in_flush[3]),
    .a(in_a[3][31:0]), .b(in_b[3][31:0]), .a_signed(in_as[3]), .b_signed(in_bs[3]),
    .half(in_h[3]), .done(done3), .c(c3));

  typedef struct packed {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         as;
    logic         bs;
    logic         h;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [17];

  function automatic logic get_done(int idx);
    case (idx)
      0:       return done0;
      1:       return done1;
      2:       return done2;
      default: return done3;
    endcase
  endfunction

  function automatic logic [127:0] get_c(int idx);
    case (idx)
      0:       return c0;
      1:       return c1;
      2:       return c2;
      default: return {64'd0, c3};
    endcase
  endfunction

  // Reference: sign/zero-extend to 130 bits and use the native multiplier.
  function automatic logic [127:0] gold(int w, logic [63:0] a, logic [63:0] b,
                                        bit as, bit bs, bit h);
    int hw;
    logic signed [129:0] ea, eb, p;
    logic [127:0] r;
    hw = h ? w / 2 : w;
    for (int i = 0; i < 130; i++) begin
      if (i < hw) begin
        ea[i] = a[i];
        eb[i] = b[i];
      end else begin
        ea[i] = as & a[hw-1];
        eb[i] = bs & b[hw-1];
      end
    end
    p = ea * eb;
    for (int i = 0; i < 128; i++) r[i] = (h && i >= hw) ? p[hw-1] : p[i];
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(int idx, logic [63:0] a, logic [63:0] b, bit as, bit bs, bit h);
    in_a[idx]  = a;
    in_b[idx]  = b;
    in_as[idx] = as;
    in_bs[idx] = bs;
    in_h[idx]  = h;
  endtask

  task automatic do_op(int idx, logic [63:0] a, logic [63:0] b, bit as, bit bs, bit h,
                       logic [127:0] exp, int lat, string name);
    int n;
    logic [127:0] e;
    e = (idx == 3) ? {64'd0, exp[63:0]} : exp;
    @(posedge clk); #1;
    set_ops(idx, a, b, as, bs, h);
    in_valid[idx] = 1'b1;
    @(negedge clk);
    chk({name, " accept-done"}, 128'(get_done(idx)), 128'd0);
    n = 0;
    while (!get_done(idx) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 128'(n), 128'(lat));
    chk({name, " c"}, get_c(idx), e);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0;
      in_flush[i] = 1'b0;
      set_ops(i, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    end

    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
    tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, 1'b0, 1'b0,
                128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1};
    tbl[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
    tbl[4]  = '{64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 1'b1, 1'b1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
    tbl[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0,
                128'h4000_0000_0000_0000_0000_0000_0000_0000};
    tbl[6]  = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1, 1'b0, 128'd0};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b1, 1'b0, 128'd0};
    tbl[8]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
    tbl[9]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
                128'h0000_0000_0000_0000_8000_0000_0000_0000};
    tbl[10] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 128'd1};
    tbl[11] = '{64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFF, 1'b1, 1'b1, 1'b1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD};
    tbl[12] = '{64'h0000_0000_1234_5678, 64'h10, 1'b0, 1'b0, 1'b0, 128'h1_2345_6780};
    tbl[13] = '{64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0,
                128'h0000_0001_0000_0000_0000_0000_0000_0000};
    tbl[14] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
    tbl[15] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b1, 1'b1, 128'd0};
    tbl[16] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 128'd1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset done d%0d", d), 128'(get_done(d)), 128'd1);
      chk($sformatf("reset c d%0d", d), get_c(d), 128'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset done d1", 128'(done1), 128'd1);

    // Directed table on each 64-bit latency variant
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 17; i++) begin
        do_op(d, tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].bs, tbl[i].h, tbl[i].exp,
              lat_of[d], $sformatf("tbl d%0d v%0d", d, i));
      end
    end

    // Flush at cnt=1 on LATENCY=3: result must not land, c keeps prior value
    do_op(2, 64'h1234_5678, 64'h10, 1'b0, 1'b0, 1'b0, 128'h1_2345_6780, 3, "preflush");
    @(posedge clk); #1;
    set_ops(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    in_valid[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_flush[2] = 1'b1;
    @(negedge clk);
    chk("flush cycle done", 128'(done2), 128'd1);
    @(posedge clk); #1;
    in_flush[2] = 1'b0;
    in_valid[2] = 1'b0;
    @(negedge clk);
    chk("after flush c", c2, 128'h1_2345_6780);
    chk("after flush done", 128'(done2), 128'd1);
    repeat (3) @(negedge clk);
    chk("flush hold c", c2, 128'h1_2345_6780);
    do_op(2, 64'd7, 64'd6, 1'b0, 1'b0, 1'b0, 128'd42, 3, "postflush");

    // Valid presented together with flush in IDLE is ignored
    do_op(1, 64'h1234_5678, 64'h10, 1'b0, 1'b0, 1'b0, 128'h1_2345_6780, 2, "prevf");
    @(posedge clk); #1;
    set_ops(1, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0);
    in_valid[1] = 1'b1;
    in_flush[1] = 1'b1;
    @(negedge clk);
    chk("valid+flush done", 128'(done1), 128'd1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    in_flush[1] = 1'b0;
    @(negedge clk);
    chk("valid+flush not busy", 128'(done1), 128'd1);
    repeat (2) @(negedge clk);
    chk("valid+flush c", c1, 128'h1_2345_6780);

    // Reset mid-operation abandons the op and clears c
    @(posedge clk); #1;
    set_ops(1, 64'd9, 64'd9, 1'b0, 1'b0, 1'b0);
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("reset midop done", 128'(done1), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset midop c", c1, 128'd0);
    chk("reset midop idle", 128'(done1), 128'd1);
    repeat (2) @(negedge clk);
    chk("reset midop no result", c1, 128'd0);

    // Latency sweep with random operands against the reference model
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 8; k++) begin
        logic [63:0] ra, rb;
        bit s1, s2, hm;
        int w;
        w  = (d == 3) ? 32 : 64;
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (k == 0) ra = (w == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        if (w == 32) begin
          ra[63:32] = 32'd0;
          rb[63:32] = 32'd0;
        end
        s1 = 1'($urandom_range(0, 1));
        s2 = 1'($urandom_range(0, 1));
        hm = (k % 3 == 2);
        do_op(d, ra, rb, s1, s2, hm, gold(w, ra, rb, s1, s2, hm), lat_of[d],
              $sformatf("rnd d%0d k%0d", d, k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
